// File: rtl/triumph_hazard_ctrl_pkg.sv
// Shared constants and state codes for the issue/hazard controller.
package triumph_hazard_ctrl_pkg;

  // Default geometry of the register file and the in-flight write window
  localparam int HZ_NREG         = 32;
  localparam int HZ_ADDR_W       = 5;
  localparam int HZ_MAX_INFLIGHT = 4;
  localparam int HZ_CNT_W        = 3;
  localparam int HZ_OP_W         = 7;

  // FSM state type and codes (code 3 is unused and recovers to RUN)
  typedef logic [1:0] hz_state_t;

  localparam hz_state_t HZ_RUN   = 2'd0;
  localparam hz_state_t HZ_STALL = 2'd1;
  localparam hz_state_t HZ_FLUSH = 2'd2;

endpackage

// File: rtl/triumph_hazard_ctrl_if.sv
// Decode / issue / writeback bundle of the hazard controller.
// Signal suffixes are from the controller's point of view.
interface triumph_hazard_ctrl_if
  import triumph_hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W = HZ_ADDR_W,
  parameter int CNT_W  = HZ_CNT_W,
  parameter int OP_W   = HZ_OP_W
);

  // decode side
  logic              instr_valid_i;
  logic              instr_ready_o;
  logic [ADDR_W-1:0] rs1_addr_i;
  logic              rs1_used_i;
  logic [ADDR_W-1:0] rs2_addr_i;
  logic              rs2_used_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic              rd_wen_i;
  logic [OP_W-1:0]   op_type_i;

  // EX side
  logic              issue_valid_o;
  logic              issue_ready_i;
  logic [ADDR_W-1:0] issue_rd_o;
  logic              issue_wen_o;
  logic [OP_W-1:0]   issue_op_o;

  // WB side and control
  logic              wb_valid_i;
  logic [ADDR_W-1:0] wb_addr_i;
  logic              flush_i;

  // status
  logic              stall_o;
  logic [CNT_W-1:0]  inflight_o;
  logic [1:0]        state_o;
  logic              err_o;

  // controller view
  modport slave (
    input  instr_valid_i, rs1_addr_i, rs1_used_i, rs2_addr_i, rs2_used_i,
           rd_addr_i, rd_wen_i, op_type_i, issue_ready_i, wb_valid_i,
           wb_addr_i, flush_i,
    output instr_ready_o, issue_valid_o, issue_rd_o, issue_wen_o, issue_op_o,
           stall_o, inflight_o, state_o, err_o
  );

  // pipeline / environment view
  modport master (
    output instr_valid_i, rs1_addr_i, rs1_used_i, rs2_addr_i, rs2_used_i,
           rd_addr_i, rd_wen_i, op_type_i, issue_ready_i, wb_valid_i,
           wb_addr_i, flush_i,
    input  instr_ready_o, issue_valid_o, issue_rd_o, issue_wen_o, issue_op_o,
           stall_o, inflight_o, state_o, err_o
  );

endinterface

// File: rtl/triumph_hazard_ctrl_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register plus a
// count of pending writes. x0 is never tracked.
module triumph_hazard_ctrl_scoreboard
  import triumph_hazard_ctrl_pkg::*;
#(
  parameter int NREG   = HZ_NREG,
  parameter int ADDR_W = HZ_ADDR_W,
  parameter int CNT_W  = HZ_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] look_a_i,
  input  logic [ADDR_W-1:0] look_b_i,
  input  logic [ADDR_W-1:0] look_c_i,
  output logic              pend_a_o,
  output logic              pend_b_o,
  output logic              pend_c_o,
  output logic [CNT_W-1:0]  inflight_o,
  output logic              clr_miss_o
);

  logic [NREG-1:0]  sb_q, sb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             set_en_s;
  logic             clr_req_s;
  logic             clr_hit_s;
  logic [NREG-1:0]  set_mask_s;
  logic [NREG-1:0]  clr_mask_s;

  assign set_en_s  = set_i & (set_addr_i != {ADDR_W{1'b0}});
  assign clr_req_s = clr_i & (clr_addr_i != {ADDR_W{1'b0}});
  assign clr_hit_s = clr_req_s & sb_q[clr_addr_i];
  // a writeback for a register with no pending write is reported, not applied
  assign clr_miss_o = clr_req_s & ~sb_q[clr_addr_i];

  assign pend_a_o   = sb_q[look_a_i];
  assign pend_b_o   = sb_q[look_b_i];
  assign pend_c_o   = sb_q[look_c_i];
  assign inflight_o = cnt_q;

  // next pending vector and count from this cycle's set/clear requests
  always_comb begin
    set_mask_s = {NREG{1'b0}};
    clr_mask_s = {NREG{1'b0}};
    if (set_en_s) begin
      set_mask_s = {{(NREG-1){1'b0}}, 1'b1} << set_addr_i;
    end else begin
      set_mask_s = {NREG{1'b0}};
    end
    if (clr_hit_s) begin
      clr_mask_s = {{(NREG-1){1'b0}}, 1'b1} << clr_addr_i;
    end else begin
      clr_mask_s = {NREG{1'b0}};
    end
    sb_d  = (sb_q | set_mask_s) & ~clr_mask_s;
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, set_en_s} - {{(CNT_W-1){1'b0}}, clr_hit_s};
  end

  // scoreboard state, discarded immediately on reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sb_q  <= {NREG{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/triumph_hazard_ctrl.sv
// Issue/hazard controller between decode and EX. Stalls decode on RAW/WAW
// hazards or when the in-flight write window is full, holds one issued
// instruction for EX, and retires pending writes on WB.
module triumph_hazard_ctrl
  import triumph_hazard_ctrl_pkg::*;
#(
  parameter int NREG         = HZ_NREG,
  parameter int ADDR_W       = HZ_ADDR_W,
  parameter int MAX_INFLIGHT = HZ_MAX_INFLIGHT,
  parameter int CNT_W        = HZ_CNT_W,
  parameter int OP_W         = HZ_OP_W
) (
  input logic                  clk_i,
  input logic                  rst_i,
  triumph_hazard_ctrl_if.slave bus
);

  // issue register, FSM and sticky error
  logic              issue_valid_q, issue_valid_d;
  logic [ADDR_W-1:0] issue_rd_q, issue_rd_d;
  logic              issue_wen_q, issue_wen_d;
  logic [OP_W-1:0]   issue_op_q, issue_op_d;
  hz_state_t         state_q, state_d;
  logic              err_q, err_d;

  // scoreboard interface
  logic              sb_pend_rs1_s;
  logic              sb_pend_rs2_s;
  logic              sb_pend_rd_s;
  logic [CNT_W-1:0]  inflight_s;
  logic              wb_miss_s;

  // decode-side evaluation
  logic              iss_wr_s;
  logic              pend_rs1_s;
  logic              pend_rs2_s;
  logic              pend_rd_s;
  logic              hazard_s;
  logic              need_slot_s;
  logic [CNT_W:0]    occupancy_s;
  logic              full_s;
  logic              run_s;
  logic              ready_s;
  logic              accept_s;
  logic              fire_s;
  logic              blocked_s;

  triumph_hazard_ctrl_scoreboard #(
    .NREG   (NREG),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_sb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_i      (fire_s & issue_wen_q),
    .set_addr_i (issue_rd_q),
    .clr_i      (bus.wb_valid_i),
    .clr_addr_i (bus.wb_addr_i),
    .look_a_i   (bus.rs1_addr_i),
    .look_b_i   (bus.rs2_addr_i),
    .look_c_i   (bus.rd_addr_i),
    .pend_a_o   (sb_pend_rs1_s),
    .pend_b_o   (sb_pend_rs2_s),
    .pend_c_o   (sb_pend_rd_s),
    .inflight_o (inflight_s),
    .clr_miss_o (wb_miss_s)
  );

  // the write held in the issue register is already pending for hazard purposes
  assign iss_wr_s   = issue_valid_q & issue_wen_q;
  assign pend_rs1_s = sb_pend_rs1_s | (iss_wr_s & (issue_rd_q == bus.rs1_addr_i));
  assign pend_rs2_s = sb_pend_rs2_s | (iss_wr_s & (issue_rd_q == bus.rs2_addr_i));
  assign pend_rd_s  = sb_pend_rd_s  | (iss_wr_s & (issue_rd_q == bus.rd_addr_i));

  assign hazard_s =
      (bus.rs1_used_i & (bus.rs1_addr_i != {ADDR_W{1'b0}}) & pend_rs1_s) |
      (bus.rs2_used_i & (bus.rs2_addr_i != {ADDR_W{1'b0}}) & pend_rs2_s) |
      (bus.rd_wen_i   & (bus.rd_addr_i  != {ADDR_W{1'b0}}) & pend_rd_s);

  // only an instruction that really writes a register needs a window slot
  assign need_slot_s = bus.rd_wen_i & (bus.rd_addr_i != {ADDR_W{1'b0}});
  assign occupancy_s = {1'b0, inflight_s} + {{CNT_W{1'b0}}, iss_wr_s};
  assign full_s      = need_slot_s & (occupancy_s >= (CNT_W+1)'(MAX_INFLIGHT));

  // STALL is an observation of a held decode, so it may still accept
  assign run_s     = (state_q == HZ_RUN) | (state_q == HZ_STALL);
  assign ready_s   = run_s & ~bus.flush_i & ~hazard_s & ~full_s &
                     (~issue_valid_q | bus.issue_ready_i);
  assign accept_s  = bus.instr_valid_i & ready_s;
  // a flush kills the held instruction even if EX takes it this cycle
  assign fire_s    = issue_valid_q & bus.issue_ready_i & ~bus.flush_i;
  assign blocked_s = bus.instr_valid_i & ~ready_s;

  // issue register next state: flush kills, accept loads, handshake empties
  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_rd_d    = issue_rd_q;
    issue_wen_d   = issue_wen_q;
    issue_op_d    = issue_op_q;
    if (bus.flush_i) begin
      issue_valid_d = 1'b0;
    end else if (accept_s) begin
      issue_valid_d = 1'b1;
      issue_rd_d    = bus.rd_addr_i;
      issue_wen_d   = need_slot_s;
      issue_op_d    = bus.op_type_i;
    end else if (fire_s) begin
      issue_valid_d = 1'b0;
    end else begin
      issue_valid_d = issue_valid_q;
    end
  end

  // FSM next state; FLUSH holds until every issued write has drained
  always_comb begin
    state_d = state_q;
    if (bus.flush_i) begin
      state_d = HZ_FLUSH;
    end else begin
      case (state_q)
        HZ_RUN, HZ_STALL: state_d = blocked_s ? HZ_STALL : HZ_RUN;
        HZ_FLUSH:         state_d = (inflight_s == {CNT_W{1'b0}}) ? HZ_RUN : HZ_FLUSH;
        default:          state_d = HZ_RUN;
      endcase
    end
  end

  assign err_d = err_q | wb_miss_s;

  // registered state of the controller
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      issue_valid_q <= 1'b0;
      issue_rd_q    <= {ADDR_W{1'b0}};
      issue_wen_q   <= 1'b0;
      issue_op_q    <= {OP_W{1'b0}};
      state_q       <= HZ_RUN;
      err_q         <= 1'b0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_rd_q    <= issue_rd_d;
      issue_wen_q   <= issue_wen_d;
      issue_op_q    <= issue_op_d;
      state_q       <= state_d;
      err_q         <= err_d;
    end
  end

  assign bus.instr_ready_o = ready_s;
  assign bus.stall_o       = blocked_s;
  assign bus.issue_valid_o = issue_valid_q;
  assign bus.issue_rd_o    = issue_rd_q;
  assign bus.issue_wen_o   = issue_wen_q;
  assign bus.issue_op_o    = issue_op_q;
  assign bus.inflight_o    = inflight_s;
  assign bus.state_o       = state_q;
  assign bus.err_o         = err_q;

endmodule

// File: tb/tb_triumph_hazard_ctrl.sv
// Bench for triumph_hazard_ctrl: directed scenarios plus a randomized run
// against a set-based reference model of the pending writes.
module tb_triumph_hazard_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  triumph_hazard_ctrl_if hif ();

  triumph_hazard_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: set of pending registers, issue slot, state, error
  bit         m_sb [32];
  bit         m_iv;
  bit         m_iw;
  logic [4:0] m_ird;
  logic [6:0] m_iop;
  int         m_state;
  bit         m_err;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_sb[i]);
    return c;
  endfunction

  function automatic bit m_pend(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    return m_sb[r] || (m_iv && m_iw && m_ird == r);
  endfunction

  function automatic bit m_ready();
    bit haz;
    bit full;
    if (m_state == 2 || hif.flush_i) return 1'b0;
    haz = (hif.rs1_used_i && m_pend(hif.rs1_addr_i)) ||
          (hif.rs2_used_i && m_pend(hif.rs2_addr_i)) ||
          (hif.rd_wen_i   && m_pend(hif.rd_addr_i));
    full = hif.rd_wen_i && hif.rd_addr_i != 5'd0 &&
           (m_count() + ((m_iv && m_iw) ? 1 : 0) >= 4);
    if (haz || full) return 1'b0;
    return !m_iv || hif.issue_ready_i;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_sb[i] = 1'b0;
    m_iv = 1'b0; m_iw = 1'b0; m_ird = 5'd0; m_iop = 7'd0;
    m_state = 0; m_err = 1'b0;
  endtask

  task automatic m_step();
    bit rdy;
    bit acc;
    bit fire;
    int cnt;
    rdy  = m_ready();
    acc  = hif.instr_valid_i && rdy;
    fire = m_iv && hif.issue_ready_i && !hif.flush_i;
    cnt  = m_count();
    if (hif.wb_valid_i && hif.wb_addr_i != 5'd0) begin
      if (m_sb[hif.wb_addr_i]) m_sb[hif.wb_addr_i] = 1'b0;
      else m_err = 1'b1;
    end
    if (fire && m_iw) m_sb[m_ird] = 1'b1;
    if (hif.flush_i) m_state = 2;
    else if (m_state == 2) m_state = (cnt == 0) ? 0 : 2;
    else m_state = (hif.instr_valid_i && !rdy) ? 1 : 0;
    if (hif.flush_i) m_iv = 1'b0;
    else if (acc) begin
      m_iv  = 1'b1;
      m_ird = hif.rd_addr_i;
      m_iw  = hif.rd_wen_i && hif.rd_addr_i != 5'd0;
      m_iop = hif.op_type_i;
    end else if (fire) m_iv = 1'b0;
  endtask

  // advance one clock: model first (inputs are stable), then sample 1 ns after edge
  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hif.instr_valid_i = 1'b0;
    hif.rs1_addr_i = 5'd0; hif.rs1_used_i = 1'b0;
    hif.rs2_addr_i = 5'd0; hif.rs2_used_i = 1'b0;
    hif.rd_addr_i  = 5'd0; hif.rd_wen_i   = 1'b0;
    hif.op_type_i  = 7'd0;
    hif.issue_ready_i = 1'b0;
    hif.wb_valid_i = 1'b0; hif.wb_addr_i = 5'd0;
    hif.flush_i = 1'b0;
  endtask

  task automatic drive_instr(input logic [4:0] rs1, input bit u1, input logic [4:0] rs2,
                             input bit u2, input logic [4:0] rd, input bit wen,
                             input logic [6:0] op);
    hif.instr_valid_i = 1'b1;
    hif.rs1_addr_i = rs1; hif.rs1_used_i = u1;
    hif.rs2_addr_i = rs2; hif.rs2_used_i = u2;
    hif.rd_addr_i  = rd;  hif.rd_wen_i   = wen;
    hif.op_type_i  = op;
  endtask

  // retire everything outstanding so the next scenario starts clean
  task automatic drain(input string tag);
    for (int n = 0; n < 40 && (m_count() != 0 || m_iv || m_state != 0); n++) begin
      idle();
      hif.issue_ready_i = 1'b1;
      for (int r = 31; r > 0; r--) begin
        if (m_sb[r]) begin
          hif.wb_valid_i = 1'b1;
          hif.wb_addr_i  = 5'(r);
        end
      end
      tick();
    end
    idle();
    checks++;
    if (hif.inflight_o !== 3'd0 || hif.state_o !== 2'd0 || hif.issue_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL drain_%s inflight=%0d state=%0d issue_valid=%0b expected 0/0/0",
               tag, hif.inflight_o, hif.state_o, hif.issue_valid_o);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (hif.issue_valid_o !== 1'b0 || hif.inflight_o !== 3'd0 || hif.state_o !== 2'd0 ||
        hif.err_o !== 1'b0 || hif.instr_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_initial iv=%0b infl=%0d st=%0d err=%0b rdy=%0b expected 0/0/0/0/1",
               hif.issue_valid_o, hif.inflight_o, hif.state_o, hif.err_o, hif.instr_ready_o);
    end
    hif.issue_ready_i = 1'b1;
    drive_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 7'h13);
    tick();
    drive_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 7'h14);
    tick();
    hif.issue_ready_i = 1'b0;
    drive_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 7'h15);
    tick();
    checks++;
    if (hif.inflight_o !== 3'd1 || hif.state_o !== 2'd1 || hif.issue_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_prestate infl=%0d st=%0d iv=%0b expected 1/1/1",
               hif.inflight_o, hif.state_o, hif.issue_valid_o);
    end
    rst = 1'b1;
    #2;
    checks++;
    if (hif.issue_valid_o !== 1'b0 || hif.inflight_o !== 3'd0 || hif.state_o !== 2'd0 ||
        hif.err_o !== 1'b0 || hif.issue_rd_o !== 5'd0 || hif.issue_wen_o !== 1'b0 ||
        hif.issue_op_o !== 7'd0) begin
      failures++;
      $display("FAIL reset_async iv=%0b infl=%0d st=%0d err=%0b rd=%0d wen=%0b op=%0h expected all 0",
               hif.issue_valid_o, hif.inflight_o, hif.state_o, hif.err_o,
               hif.issue_rd_o, hif.issue_wen_o, hif.issue_op_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (hif.state_o !== 2'd0 || hif.issue_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_held st=%0d iv=%0b expected 0/0", hif.state_o, hif.issue_valid_o);
    end
    rst = 1'b0;
    m_reset();
    idle();
    tick();
  endtask

  task automatic test_raw();
    hif.issue_ready_i = 1'b1;
    drive_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 7'h11);
    #1;
    checks++;
    if (hif.instr_ready_o !== 1'b1) begin
      failures++; $display("FAIL raw_first_ready got=%0b exp=1", hif.instr_ready_o);
    end
    tick();
    drive_instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 7'h22);
    for (int c = 0; c < 3; c++) begin
      hif.wb_valid_i = (c == 2);
      hif.wb_addr_i  = (c == 2) ? 5'd5 : 5'd0;
      #1;
      checks++;
      if (hif.stall_o !== 1'b1) begin
        failures++; $display("FAIL raw_stall cycle=%0d got=%0b exp=1", c, hif.stall_o);
      end
      tick();
      checks++;
      if (hif.inflight_o !== ((c == 2) ? 3'd0 : 3'd1) || hif.state_o !== 2'd1) begin
        failures++;
        $display("FAIL raw_pending cycle=%0d infl=%0d st=%0d expected %0d/1",
                 c, hif.inflight_o, hif.state_o, (c == 2) ? 0 : 1);
      end
    end
    hif.wb_valid_i = 1'b0;
    hif.wb_addr_i  = 5'd0;
    #1;
    checks++;
    if (hif.stall_o !== 1'b0 || hif.instr_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL raw_release stall=%0b rdy=%0b expected 0/1", hif.stall_o, hif.instr_ready_o);
    end
    tick();
    checks++;
    if (hif.issue_valid_o !== 1'b1 || hif.issue_op_o !== 7'h22 || hif.issue_wen_o !== 1'b0 ||
        hif.state_o !== 2'd0) begin
      failures++;
      $display("FAIL raw_issue iv=%0b op=%0h wen=%0b st=%0d expected 1/22/0/0",
               hif.issue_valid_o, hif.issue_op_o, hif.issue_wen_o, hif.state_o);
    end
    drain("raw");
  endtask

  task automatic test_x0();
    hif.issue_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_instr(5'd0, 1'b1, 5'd0, 1'(i), 5'd0, 1'b1, 7'(i + 40));
      #1;
      checks++;
      if (hif.stall_o !== 1'b0) begin
        failures++; $display("FAIL x0_stall i=%0d got=%0b exp=0", i, hif.stall_o);
      end
      tick();
      checks++;
      if (hif.issue_valid_o !== 1'b1 || hif.issue_wen_o !== 1'b0 || hif.inflight_o !== 3'd0 ||
          hif.issue_op_o !== 7'(i + 40)) begin
        failures++;
        $display("FAIL x0_issue i=%0d iv=%0b wen=%0b infl=%0d op=%0d expected 1/0/0/%0d",
                 i, hif.issue_valid_o, hif.issue_wen_o, hif.inflight_o, hif.issue_op_o, i + 40);
      end
    end
    drain("x0");
  endtask

  task automatic test_limit();
    hif.issue_ready_i = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      drive_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'(r), 1'b1, 7'(r));
      #1;
      checks++;
      if (hif.instr_ready_o !== 1'b1) begin
        failures++; $display("FAIL limit_fill r=%0d rdy=%0b exp=1", r, hif.instr_ready_o);
      end
      tick();
    end
    drive_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 7'h05);
    for (int c = 0; c < 4; c++) begin
      hif.wb_valid_i = (c == 3);
      hif.wb_addr_i  = (c == 3) ? 5'd2 : 5'd0;
      #1;
      checks++;
      if (hif.stall_o !== 1'b1) begin
        failures++; $display("FAIL limit_stall cycle=%0d got=%0b exp=1", c, hif.stall_o);
      end
      tick();
      checks++;
      if (hif.inflight_o !== ((c == 3) ? 3'd3 : 3'd4)) begin
        failures++;
        $display("FAIL limit_inflight cycle=%0d got=%0d exp=%0d", c, hif.inflight_o, (c == 3) ? 3 : 4);
      end
    end
    hif.wb_valid_i = 1'b0;
    hif.wb_addr_i  = 5'd0;
    #1;
    checks++;
    if (hif.stall_o !== 1'b0) begin
      failures++; $display("FAIL limit_release stall got=%0b exp=0", hif.stall_o);
    end
    tick();
    checks++;
    if (hif.issue_valid_o !== 1'b1 || hif.issue_rd_o !== 5'd5 || hif.issue_wen_o !== 1'b1) begin
      failures++;
      $display("FAIL limit_issue iv=%0b rd=%0d wen=%0b expected 1/5/1",
               hif.issue_valid_o, hif.issue_rd_o, hif.issue_wen_o);
    end
    drain("limit");
  endtask

  task automatic test_backpressure();
    hif.issue_ready_i = 1'b0;
    drive_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 7'h2A);
    tick();
    drive_instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 7'h3B);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (hif.instr_ready_o !== 1'b0 || hif.stall_o !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold_in cycle=%0d rdy=%0b stall=%0b expected 0/1", c, hif.instr_ready_o, hif.stall_o);
      end
      tick();
      checks++;
      if (hif.issue_valid_o !== 1'b1 || hif.issue_rd_o !== 5'd6 || hif.issue_op_o !== 7'h2A ||
          hif.inflight_o !== 3'd0) begin
        failures++;
        $display("FAIL bp_hold_out cycle=%0d iv=%0b rd=%0d op=%0h infl=%0d expected 1/6/2a/0",
                 c, hif.issue_valid_o, hif.issue_rd_o, hif.issue_op_o, hif.inflight_o);
      end
    end
    hif.issue_ready_i = 1'b1;
    #1;
    checks++;
    if (hif.instr_ready_o !== 1'b1) begin
      failures++; $display("FAIL bp_release rdy=%0b exp=1", hif.instr_ready_o);
    end
    tick();
    checks++;
    if (hif.issue_rd_o !== 5'd7 || hif.issue_op_o !== 7'h3B || hif.inflight_o !== 3'd1) begin
      failures++;
      $display("FAIL bp_next rd=%0d op=%0h infl=%0d expected 7/3b/1",
               hif.issue_rd_o, hif.issue_op_o, hif.inflight_o);
    end
    drain("bp");
  endtask

  task automatic test_flush();
    hif.issue_ready_i = 1'b1;
    drive_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 7'h01);
    tick();
    drive_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 7'h02);
    tick();
    drive_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 7'h07);
    tick();
    idle();
    hif.issue_ready_i = 1'b1;
    hif.flush_i = 1'b1;
    #1;
    checks++;
    if (hif.instr_ready_o !== 1'b0) begin
      failures++; $display("FAIL flush_ready got=%0b exp=0", hif.instr_ready_o);
    end
    tick();
    checks++;
    if (hif.issue_valid_o !== 1'b0 || hif.state_o !== 2'd2 || hif.inflight_o !== 3'd2) begin
      failures++;
      $display("FAIL flush_kill iv=%0b st=%0d infl=%0d expected 0/2/2",
               hif.issue_valid_o, hif.state_o, hif.inflight_o);
    end
    hif.flush_i = 1'b0;
    drive_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 7'h0A);
    for (int c = 0; c < 3; c++) begin
      hif.wb_valid_i = (c != 0);
      hif.wb_addr_i  = 5'(c);
      #1;
      checks++;
      if (hif.instr_ready_o !== 1'b0) begin
        failures++; $display("FAIL flush_blocked cycle=%0d rdy=%0b exp=0", c, hif.instr_ready_o);
      end
      tick();
      checks++;
      if (hif.state_o !== 2'd2 || hif.inflight_o !== 3'(2 - (c == 0 ? 0 : c))) begin
        failures++;
        $display("FAIL flush_drain cycle=%0d st=%0d infl=%0d expected 2/%0d",
                 c, hif.state_o, hif.inflight_o, 2 - c);
      end
    end
    hif.wb_valid_i = 1'b0;
    hif.wb_addr_i  = 5'd0;
    tick();
    checks++;
    if (hif.state_o !== 2'd0 || hif.issue_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_exit st=%0d iv=%0b expected 0/0", hif.state_o, hif.issue_valid_o);
    end
    drive_instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 7'h77);
    #1;
    checks++;
    if (hif.stall_o !== 1'b0) begin
      failures++; $display("FAIL flush_x7_clear stall=%0b exp=0", hif.stall_o);
    end
    tick();
    idle();
    hif.wb_valid_i = 1'b1;
    hif.wb_addr_i  = 5'd9;
    tick();
    hif.wb_valid_i = 1'b0;
    hif.wb_addr_i  = 5'd0;
    checks++;
    if (hif.err_o !== 1'b1) begin
      failures++; $display("FAIL flush_stray_err got=%0b exp=1", hif.err_o);
    end
    tick();
    tick();
    checks++;
    if (hif.err_o !== 1'b1) begin
      failures++; $display("FAIL err_sticky got=%0b exp=1", hif.err_o);
    end
    drain("flush");
  endtask

  task automatic test_random();
    int q[$];
    for (int n = 0; n < 600; n++) begin
      hif.instr_valid_i = ($urandom_range(3, 0) != 0);
      hif.rs1_addr_i = 5'($urandom_range(7, 0)); hif.rs1_used_i = 1'($urandom_range(1, 0));
      hif.rs2_addr_i = 5'($urandom_range(7, 0)); hif.rs2_used_i = 1'($urandom_range(1, 0));
      hif.rd_addr_i  = 5'($urandom_range(7, 0)); hif.rd_wen_i   = 1'($urandom_range(1, 0));
      hif.op_type_i  = 7'($urandom_range(127, 0));
      hif.issue_ready_i = ($urandom_range(3, 0) != 0);
      hif.flush_i = ($urandom_range(24, 0) == 0);
      hif.wb_valid_i = 1'b0;
      hif.wb_addr_i  = 5'd0;
      q.delete();
      for (int r = 1; r < 32; r++) if (m_sb[r]) q.push_back(r);
      if (q.size() > 0 && $urandom_range(2, 0) == 0) begin
        hif.wb_valid_i = 1'b1;
        hif.wb_addr_i  = 5'(q[$urandom_range(q.size() - 1, 0)]);
      end else if ($urandom_range(19, 0) == 0) begin
        hif.wb_valid_i = 1'b1;
        hif.wb_addr_i  = 5'($urandom_range(31, 0));
      end
      #1;
      checks++;
      if (hif.instr_ready_o !== m_ready() ||
          hif.stall_o !== (hif.instr_valid_i && !m_ready())) begin
        failures++;
        $display("FAIL rand_comb n=%0d rdy=%0b stall=%0b expected rdy=%0b stall=%0b", n,
                 hif.instr_ready_o, hif.stall_o, m_ready(), hif.instr_valid_i && !m_ready());
      end
      tick();
      checks++;
      if (hif.issue_valid_o !== m_iv || hif.state_o !== 2'(m_state) ||
          hif.inflight_o !== 3'(m_count()) || hif.err_o !== m_err ||
          (m_iv && (hif.issue_rd_o !== m_ird || hif.issue_wen_o !== m_iw ||
                    hif.issue_op_o !== m_iop))) begin
        failures++;
        $display("FAIL rand_state n=%0d iv=%0b st=%0d infl=%0d err=%0b rd=%0d wen=%0b op=%0h expected %0b/%0d/%0d/%0b/%0d/%0b/%0h",
                 n, hif.issue_valid_o, hif.state_o, hif.inflight_o, hif.err_o, hif.issue_rd_o,
                 hif.issue_wen_o, hif.issue_op_o, m_iv, m_state, m_count(), m_err, m_ird, m_iw, m_iop);
      end
    end
    drain("random");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    idle();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    test_reset();
    test_raw();
    test_x0();
    test_limit();
    test_backpressure();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
